// File: rtl/chan_fifo_pkg.sv
// Shared width helpers for the channel FIFO slice.
package chan_fifo_pkg;

    // Pointer width for a FIFO addressed with aw bits: one extra wrap bit
    // distinguishes "all slots unread" from "nothing unread".
    function automatic int unsigned ptr_width(input int unsigned aw);
        return aw + 1;
    endfunction

    // Ceiling log2, for callers that size fields from a depth.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/d_p_ram.sv
// Simple dual-port RAM: one synchronous write port and one read port whose
// output is registered (one cycle of read latency). Contents are not reset.
module d_p_ram #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  write_en_i,
    input  logic [ADDR_WIDTH-1:0] write_addr_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_i,
    output logic [DATA_WIDTH-1:0] output_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed word and register the read word every cycle.
    always_ff @(posedge clk_i) begin
        if (write_en_i) begin
            mem_q[write_addr_i] <= write_data_i;
        end
        output_data_o <= mem_q[read_addr_i];
    end

endmodule

// File: rtl/chan_fifo.sv
// Channel FIFO controller around a registered-output dual-port RAM.
// The head word is held in the RAM output register itself: while the head is
// not consumed the controller keeps re-reading the head slot, so out_data is
// stable; when it is consumed the next unread slot is fetched in the same
// cycle, giving back-to-back pops with no bubbles.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and once out_valid is high it
// stays high with out_data unchanged until the transfer takes place.
module chan_fifo
    import chan_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned PW = ptr_width(ADDR_WIDTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  out_valid_q, out_valid_d;

    logic                  push;
    logic                  pop;
    logic                  unread;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [ADDR_WIDTH-1:0] read_addr;

    // The head slot stays inside count until popped, so a full count also
    // protects the slot currently shown on out_data from being overwritten.
    assign in_ready  = (count_q != PW'(DEPTH));
    assign out_valid = out_valid_q;
    assign count     = count_q;

    assign push       = in_valid && in_ready;
    assign pop        = out_valid_q && out_ready;
    assign unread     = (wr_ptr_q != rd_ptr_q);
    assign issue      = unread && (!out_valid_q || out_ready);
    assign write_addr = wr_ptr_q[ADDR_WIDTH-1:0];

    // Fetch the next unread slot when the head is free, else re-read the head.
    always_comb begin
        read_addr = rd_ptr_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
        if (issue) begin
            read_addr = rd_ptr_q[ADDR_WIDTH-1:0];
        end
    end

    // Next-state for pointers, occupancy and head validity.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(issue);
        count_d     = count_q + PW'(push) - PW'(pop);
        out_valid_d = out_valid_q;
        if (issue) begin
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state; reset drops every stored word and any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    d_p_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i         (clk),
        .write_en_i    (push),
        .write_addr_i  (write_addr),
        .write_data_i  (in_data),
        .read_addr_i   (read_addr),
        .output_data_o (out_data)
    );

endmodule

// File: tb/tb_chan_fifo.sv
// Directed plus randomized bench for chan_fifo. The reference model is a
// queue of stored words with the edge each was pushed on; the head becomes
// visible one edge after its push, or on the edge its predecessor is
// popped, whichever is later.
module tb_chan_fifo;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;

    chan_fifo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            edge_n   = 0;
    int            head_vis = 0;
    int            last_pop = 0;
    int            popped   = 0;
    logic [DW-1:0] exp_q[$];
    int            pe_q[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the model.
    task automatic check_state(input string tag);
        bit exp_valid;
        exp_valid = (exp_q.size() > 0) && (edge_n >= head_vis);
        check({tag, ".count"}, DW'(count), DW'(exp_q.size()));
        check({tag, ".in_ready"}, DW'(in_ready), DW'(exp_q.size() != DEPTH));
        check({tag, ".out_valid"}, DW'(out_valid), DW'(exp_valid));
        if (exp_valid) begin
            check({tag, ".out_data"}, out_data, exp_q[0]);
        end
    endtask

    // One clock: decide transfers from the model, advance it, then check.
    task automatic cycle(input string tag);
        bit exp_valid;
        bit push;
        bit pop;
        exp_valid = (exp_q.size() > 0) && (edge_n >= head_vis);
        push = in_valid && (exp_q.size() != DEPTH);
        pop  = exp_valid && out_ready;
        @(posedge clk);
        edge_n++;
        if (pop) begin
            void'(exp_q.pop_front());
            void'(pe_q.pop_front());
            last_pop = edge_n;
            popped++;
        end
        if (push) begin
            exp_q.push_back(in_data);
            pe_q.push_back(edge_n);
        end
        if ((exp_q.size() > 0) && (pop || (push && exp_q.size() == 1))) begin
            head_vis = (pe_q[0] + 1 > last_pop) ? pe_q[0] + 1 : last_pop;
        end
        #1;
        check_state(tag);
    endtask

    // Asynchronous reset asserted away from the clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        pe_q.delete();
        check("reset.count", DW'(count), '0);
        check("reset.out_valid", DW'(out_valid), '0);
        check("reset.in_ready", DW'(in_ready), DW'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int pushed;
        int start_pop;
        bit will_push;

        // Reset release, idle.
        do_reset();
        cycle("idle");
        cycle("idle");

        // Single word held under backpressure, then popped.
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0001;
        cycle("single_push");
        in_valid = 1'b0;
        check("latency.not_yet", DW'(out_valid), '0);
        cycle("single_lat");
        check("latency.visible", DW'(out_valid), DW'(1));
        repeat (10) cycle("single_hold");
        out_ready = 1'b1;
        cycle("single_pop");
        out_ready = 1'b0;
        cycle("single_after");

        // Fill to capacity; the ninth push must be ignored. Then drain.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            cycle("fill");
        end
        in_valid = 1'b0;
        check("fill.full_count", DW'(count), DW'(DEPTH));
        out_ready = 1'b1;
        repeat (10) cycle("drain");
        out_ready = 1'b0;

        // Full with a simultaneous push attempt and pop.
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h300 + DW'(i);
            cycle("refill");
        end
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        cycle("full_pop");
        check("full_pop.count", DW'(count), DW'(DEPTH - 1));
        in_valid = 1'b0;
        repeat (10) cycle("full_drain");
        out_ready = 1'b0;

        // Streaming at one word per cycle in both directions.
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd100 + DW'(i);
            cycle("stream");
        end
        in_valid = 1'b0;
        repeat (4) cycle("stream_tail");
        out_ready = 1'b0;

        // Random valid and ready, 200 incrementing words.
        pushed    = 0;
        start_pop = popped;
        for (int c = 0; c < 5000 && (popped - start_pop) < 200; c++) begin
            in_valid  = (pushed < 200) && ($urandom_range(0, 1) == 1);
            in_data   = 32'd1000 + DW'(pushed);
            out_ready = ($urandom_range(0, 1) == 1);
            will_push = in_valid && (exp_q.size() != DEPTH);
            cycle("random");
            if (will_push) pushed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("random.pushed", DW'(pushed), DW'(200));
        check("random.popped", DW'(popped - start_pop), DW'(200));

        // Reset mid-stream with five words stored.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h500 + DW'(i);
            cycle("pre_reset");
        end
        in_valid = 1'b0;
        check("pre_reset.count", DW'(count), DW'(5));
        do_reset();
        cycle("post_reset");
        cycle("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
